rtype_issue: RTL

- Producer end of the R-type ALU interface. Accepts one 32-bit RV32I instruction per handshake and decodes and legality-checks it.
- Reads rs1/rs2 from an internal register file, drives registered instr/in1/in2 to the combinational R-type ALU, captures the ALU result and writes it back to rd.
- Sits between the fetch/sequencer and the R-type ALU. Holds architectural integer register state.

---
 rtl/rv_rtype_pkg.sv | 25 ++
 rtl/rtype_regfile.sv | 34 +++
 rtl/rtype_issue.sv | 86 ++++++++
 3 files changed

// File: rtl/rv_rtype_pkg.sv
// rv_rtype_pkg: shared R-type opcode constants, ALU op encoding, issue FSM states and legality helper.
package rv_rtype_pkg;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  // ALU op is {instr[30], funct3}
  typedef enum logic [3:0] {
    add    = 4'b0000,
    sll    = 4'b0001,
    slt    = 4'b0010,
    sltu   = 4'b0011,
    xor_op = 4'b0100,
    srl    = 4'b0101,
    or_op  = 4'b0110,
    and_op = 4'b0111,
    sub    = 4'b1000,
    sra    = 4'b1101
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} issue_state_t;
  function automatic logic is_legal(input logic [31:0] i);
    return i[6:0] == OPC_RTYPE &&
           (i[31:25] == F7_BASE ||
            (i[31:25] == F7_ALT && (i[14:12] == 3'b000 || i[14:12] == 3'b101)));
  endfunction
endpackage

// File: rtl/rtype_regfile.sv
// rtype_regfile: REG_CNT x XLEN integer register file, x0 reads zero.
// Ports: rs1/rs2/dbg read ports (combinational), wb and ext write ports
// (wb wins on same-address collision), synchronous active-high reset clears all entries.
module rtype_regfile #(
  parameter int XLEN    = 32,
  parameter int REG_CNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] dbg_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ext_we,
  input  logic [4:0]      ext_addr,
  input  logic [XLEN-1:0] ext_data
);
  logic [XLEN-1:0] r [REG_CNT];
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_CNT; i++) begin
      if (rst) r[i] <= '0;
      else if (i != 0 && wb_we && wb_addr == 5'(i)) r[i] <= wb_data;
      else if (i != 0 && ext_we && ext_addr == 5'(i)) r[i] <= ext_data;
    end
  end
  assign rs1_data = rs1_addr == '0 ? '0 : r[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : r[rs2_addr];
  assign dbg_data = dbg_addr == '0 ? '0 : r[dbg_addr];
endmodule

// File: rtl/rtype_issue.sv
// rtype_issue: R-type issue stage; accepts an instruction, checks legality, reads operands,
// drives the external combinational ALU and writes the result back (IDLE->DECODE->EXEC->WB).
// Ports: instr_valid/instr_ready/instr handshake; alu_instr/alu_in1/alu_in2 to ALU, alu_out back;
// wb_valid/wb_rd/wb_data writeback pulse; illegal reject pulse; ext_* preload write; dbg_* read.
module rtype_issue
  import rv_rtype_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_CNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [31:0]     alu_instr,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic            ext_we,
  input  logic [4:0]      ext_waddr,
  input  logic [XLEN-1:0] ext_wdata,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  issue_state_t state, state_nx;
  logic [31:0] ir;
  logic [XLEN-1:0] result, rs1_data, rs2_data;
  logic legal;
  assign legal = is_legal(ir);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = instr_valid ? DECODE : IDLE;
      DECODE:  state_nx = legal ? EXEC : IDLE;
      EXEC:    state_nx = WB;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    instr_ready = state == IDLE;
    wb_valid    = state == WB;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      alu_instr <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == DECODE && legal) begin
        alu_instr <= ir;
        alu_in1   <= rs1_data;
        alu_in2   <= rs2_data;
      end
      if (state == EXEC) result <= alu_out;
      illegal <= state == DECODE && !legal;
    end
  end
  assign wb_rd   = ir[11:7];
  assign wb_data = result;
  rtype_regfile #(.XLEN(XLEN), .REG_CNT(REG_CNT)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (ir[19:15]),
    .rs2_addr (ir[24:20]),
    .dbg_addr (dbg_raddr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_rdata),
    .wb_we    (wb_valid),
    .wb_addr  (ir[11:7]),
    .wb_data  (result),
    .ext_we   (ext_we),
    .ext_addr (ext_waddr),
    .ext_data (ext_wdata)
  );
endmodule
